// File: rtl/text_glyph_fetch.sv
// Text-mode glyph fetcher: reads one font ROM row per character and serializes it MSB first.
// Define TEXT_BLINK_EN to turn attr[7] into a blink bit (8 background colours).
module text_glyph_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start,
  input  logic [3:0]  row,
  input  logic        char_valid,
  input  logic [7:0]  char_code,
  input  logic [7:0]  char_attr,
  output logic        char_ready,
  input  logic        blink_phase,
  output logic        rom_cs,
  output logic        rom_we,
  output logic [11:0] rom_addr,
  output logic [7:0]  rom_wdata,
  input  logic [7:0]  rom_rdata,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_on,
  output logic [3:0]  pix_color
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StHold} state_e;

  state_e      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  attr_q, attr_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  pix_attr_q, pix_attr_d;
  logic [3:0]  count_q, count_d;
  logic        can_load;
  logic [3:0]  fg, bg;

  assign char_ready = (state_q == StIdle) && !rst && !line_start;
  assign rom_cs     = (state_q == StAddr);
  assign rom_we     = 1'b0;
  assign rom_addr   = addr_q;
  assign rom_wdata  = 8'h00;
  assign pix_valid  = (count_q != 4'd0);
  assign pix_on     = shift_q[7];

  // Loading on the last pixel's handshake keeps consecutive glyphs gapless.
  assign can_load = (count_q == 4'd0) || ((count_q == 4'd1) && pix_ready);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    addr_d     = addr_q;
    attr_d     = attr_q;
    hold_d     = hold_q;
    shift_d    = shift_q;
    count_d    = count_q;
    pix_attr_d = pix_attr_q;

    if (pix_valid && pix_ready) begin
      shift_d = {shift_q[6:0], 1'b0};
      count_d = count_q - 4'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (char_valid && char_ready) begin
          addr_d  = {char_code, row_q};
          attr_d  = char_attr;
          state_d = StAddr;
        end
      end
      StAddr: state_d = StData;
      StData: begin
        if (can_load) begin
          shift_d    = rom_rdata;
          count_d    = 4'd8;
          pix_attr_d = attr_q;
          state_d    = StIdle;
        end else begin
          hold_d  = rom_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        if (can_load) begin
          shift_d    = hold_q;
          count_d    = 4'd8;
          pix_attr_d = attr_q;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new line drops everything queued, including a read still in flight.
    if (line_start) begin
      state_d = StIdle;
      count_d = 4'd0;
      hold_d  = 8'h00;
      row_d   = row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= 4'd0;
      addr_q     <= 12'd0;
      attr_q     <= 8'h00;
      hold_q     <= 8'h00;
      shift_q    <= 8'h00;
      pix_attr_q <= 8'h00;
      count_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      attr_q     <= attr_d;
      hold_q     <= hold_d;
      shift_q    <= shift_d;
      pix_attr_q <= pix_attr_d;
      count_q    <= count_d;
    end
  end

`ifdef TEXT_BLINK_EN
  always_comb begin
    bg = {1'b0, pix_attr_q[6:4]};
    fg = (pix_attr_q[7] && blink_phase) ? bg : pix_attr_q[3:0];
  end
`else
  logic unused_blink_phase;
  assign unused_blink_phase = blink_phase;

  always_comb begin
    bg = pix_attr_q[7:4];
    fg = pix_attr_q[3:0];
  end
`endif

  assign pix_color = pix_on ? fg : bg;

endmodule

// File: tb/tb_text_glyph_fetch.sv
// Bench for text_glyph_fetch: queue-based pixel model, synchronous ROM model, directed and random
// stimulus. Build with TEXT_BLINK_EN defined to cover the blink variant.
module tb_text_glyph_fetch;

  logic        clk = 1'b0;
  logic        rst, line_start, char_valid, char_ready, blink_phase;
  logic [3:0]  row;
  logic [7:0]  char_code, char_attr;
  logic        rom_cs, rom_we;
  logic [11:0] rom_addr;
  logic [7:0]  rom_wdata, rom_rdata;
  logic        pix_valid, pix_ready, pix_on;
  logic [3:0]  pix_color;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  text_glyph_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .line_start (line_start),
    .row        (row),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_attr  (char_attr),
    .char_ready (char_ready),
    .blink_phase(blink_phase),
    .rom_cs     (rom_cs),
    .rom_we     (rom_we),
    .rom_addr   (rom_addr),
    .rom_wdata  (rom_wdata),
    .rom_rdata  (rom_rdata),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_on     (pix_on),
    .pix_color  (pix_color)
  );

  // Font contents: two pinned rows, everything else a fixed hash of the address.
  function automatic logic [7:0] glyph(input logic [11:0] a);
    logic [15:0] h;
    if (a == 12'h415) return 8'hC6;
    if (a == 12'h425) return 8'h66;
    h = {4'd0, a} * 16'd40503;
    return h[15:8] ^ h[7:0];
  endfunction

  function automatic logic [3:0] model_color(input logic on, input logic [7:0] attr,
                                             input logic bp);
    logic [3:0] fg, bg;
`ifdef TEXT_BLINK_EN
    bg = {1'b0, attr[6:4]};
    fg = (attr[7] && bp) ? bg : attr[3:0];
`else
    bg = attr[7:4];
    fg = attr[3:0];
`endif
    return on ? fg : bg;
  endfunction

  always @(posedge clk) if (rom_cs) rom_rdata <= glyph(rom_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {logic on; logic [7:0] attr;} px_t;

  px_t         pq[$];
  logic [3:0]  obs[$];
  logic [3:0]  row_m = 4'd0;
  logic [11:0] last_addr = 12'd0;
  logic [11:0] cs_addr = 12'd0;
  logic        acc_prev = 1'b0;
  logic        pv_prev = 1'b0;
  logic        rst_edge = 1'b0;
  int          acc_cyc = 0, pv_rise_cyc = 0, run_len = 0, max_run = 0;

  always @(posedge clk) rst_edge <= rst;

  always @(negedge clk) begin : monitor
    logic       acc;
    logic [7:0] g;
    logic [3:0] ec;
    px_t        px;
    chk("rom_we", {63'd0, rom_we}, 64'd0);
    chk("rom_wdata", {56'd0, rom_wdata}, 64'd0);
    if (rst) begin
      chk("ready_in_rst", {63'd0, char_ready}, 64'd0);
      if (rst_edge)
        chk("rst_outputs", {45'd0, pix_valid, pix_on, pix_color, rom_cs, rom_addr}, 64'd0);
      pq.delete();
      row_m    = 4'd0;
      acc_prev = 1'b0;
      pv_prev  = 1'b0;
      run_len  = 0;
    end else begin
      chk("rom_cs_timing", {63'd0, rom_cs}, {63'd0, acc_prev});
      if (rom_cs) begin
        chk("rom_addr", {52'd0, rom_addr}, {52'd0, last_addr});
        cs_addr = rom_addr;
      end
      if (line_start) chk("ready_in_line_start", {63'd0, char_ready}, 64'd0);
      if (pix_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (!pv_prev) pv_rise_cyc = cyc;
        if (pq.size() == 0) begin
          chk("pix_unexpected", {63'd0, pix_valid}, 64'd0);
        end else begin
          ec = model_color(pq[0].on, pq[0].attr, blink_phase);
          chk("pixel", {59'd0, pix_on, pix_color}, {59'd0, pq[0].on, ec});
          if (pix_ready) begin
            obs.push_back(pix_color);
            void'(pq.pop_front());
          end
        end
      end else begin
        run_len = 0;
      end
      pv_prev = pix_valid;
      acc = char_valid && char_ready;
      if (acc) begin
        last_addr = {char_code, row_m};
        g = glyph(last_addr);
        acc_cyc = cyc;
        for (int i = 7; i >= 0; i--) begin
          px.on   = g[i];
          px.attr = char_attr;
          pq.push_back(px);
        end
      end
      if (line_start) begin
        pq.delete();
        row_m = row;
      end
      acc_prev = acc;
    end
  end

  function automatic logic [63:0] pack_obs(input int n);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n && i < obs.size(); i++) v = {v[59:0], obs[i]};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] c, input logic [7:0] a);
    char_valid = 1'b1;
    char_code  = c;
    char_attr  = a;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (char_ready) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    tick();
    char_valid = 1'b0;
  endtask

  task automatic new_line(input logic [3:0] r);
    line_start = 1'b1;
    row        = r;
    tick();
    line_start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] snap;
    logic [31:0] blink_exp;
    int n;
    rst = 1'b1; line_start = 1'b0; row = 4'd0; char_valid = 1'b0;
    char_code = 8'h00; char_attr = 8'h00; blink_phase = 1'b0; pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {63'd0, char_ready}, 64'd1);
    tick();

    // Single glyph
    new_line(4'd5);
    obs.delete();
    offer(8'h41, 8'h1E);
    wait_accept();
    repeat (14) tick();
    chk("single_count", obs.size(), 8);
    chk("single_colors", pack_obs(8), 64'hEE111EE1);
    chk("single_latency", pv_rise_cyc - acc_cyc, 3);
    chk("single_addr", {52'd0, cs_addr}, 64'h415);
    chk("single_idle", {63'd0, pix_valid}, 64'd0);

    // Back-to-back
    obs.delete(); max_run = 0;
    offer(8'h41, 8'h1E); wait_accept();
    offer(8'h42, 8'h1E); wait_accept();
    repeat (20) tick();
    chk("b2b_colors", pack_obs(16), 64'hEE111EE1_1EE11EE1);
    chk("b2b_run", max_run, 16);

    // Stall after pixel 3 with a third character offered
    obs.delete(); max_run = 0;
    offer(8'h41, 8'h1E); wait_accept();
    offer(8'h42, 8'h1E); wait_accept();
    offer(8'h43, 8'h1E);
    n = 0;
    while (obs.size() < 3 && n < 50) begin tick(); n++; end
    pix_ready = 1'b0;
    #2;
    snap = {pix_valid, pix_on, pix_color};
    chk("stall_start_valid", {63'd0, pix_valid}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_hold", {58'd0, pix_valid, pix_on, pix_color}, {58'd0, snap});
      chk("stall_ready", {62'd0, char_ready, rom_cs}, 64'd0);
      tick(); #2;
    end
    pix_ready = 1'b1;
    wait_accept();
    repeat (30) tick();
    chk("stall_count", obs.size(), 24);
    chk("stall_colors", pack_obs(16), 64'hEE111EE1_1EE11EE1);
    chk("stall_run", max_run, 34);

    // Flush during pixel 4 with the next read in flight
    obs.delete();
    offer(8'h41, 8'h1E); wait_accept();
    n = 0;
    while (obs.size() < 2 && n < 50) begin tick(); n++; end
    offer(8'h42, 8'h1E); wait_accept();
    line_start = 1'b1; row = 4'd2;
    #2;
    chk("flush_cs_in_flight", {62'd0, pix_valid, rom_cs}, 64'd3);
    tick();
    line_start = 1'b0;
    #2;
    chk("flush_next", {61'd0, pix_valid, rom_cs, char_ready}, 64'd1);
    offer(8'h44, 8'h1E); wait_accept();
    repeat (14) tick();
    chk("flush_addr", {52'd0, cs_addr}, 64'h442);
    chk("flush_count", obs.size(), 12);
    chk("flush_colors", pack_obs(4), 64'hEE11);

    // Blink
    new_line(4'd5);
    blink_phase = 1'b1;
    obs.delete();
    offer(8'h41, 8'h9E); wait_accept();
    repeat (14) tick();
`ifdef TEXT_BLINK_EN
    blink_exp = 32'h11111111;
`else
    blink_exp = 32'hEE999EE9;
`endif
    chk("blink_colors", pack_obs(8), {32'd0, blink_exp});
    blink_phase = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 499) == 0);
      line_start  = ($urandom_range(0, 59) == 0);
      row         = 4'($urandom);
      char_valid  = ($urandom_range(0, 9) < 6);
      char_code   = 8'($urandom);
      char_attr   = 8'($urandom);
      pix_ready   = ($urandom_range(0, 3) != 0);
      blink_phase = 1'($urandom);
      tick();
    end
    rst = 1'b0; line_start = 1'b0; char_valid = 1'b0; pix_ready = 1'b1;
    repeat (40) tick();
    chk("drain_queue", pq.size(), 0);
    chk("drain_valid", {63'd0, pix_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_glyph_fetch.md
# text_glyph_fetch

Text-mode glyph fetcher and pixel serializer for the VGA path. It accepts character/attribute pairs from the text buffer over a valid/ready handshake and reads the 8-bit glyph row from the character generator ROM. It then shifts that row out one pixel per accepted cycle, MSB first, as a 4-bit colour index. It is the reading end of the font ROM's port: it drives `cs`, `we`, `addr` and `wdata`, and consumes `rdata` with one-cycle synchronous read latency.

## Interface
Parameters: none.
- `clk`  in  1  system clock; also clocks the font ROM.
- `rst`  in  1  synchronous, active-high reset.
- `line_start`  in  1  pulse; latches `row`, flushes the pipeline.
- `row`  in  4  glyph scanline (0–15), sampled when `line_start`=1.
- `char_valid`  in  1  char/attr pair offered.
- `char_code`  in  8  character code.
- `char_attr`  in  8  attribute: [3:0] fg, [7:4] bg (see Configuration).
- `char_ready`  out  1  fetcher accepts the pair this cycle.
- `blink_phase`  in  1  blink phase; used only with the macro set.
- `rom_cs`  out  1  font ROM enable.
- `rom_we`  out  1  font ROM write enable, constant 0 (read only).
- `rom_addr`  out  12  {char_code, row}.
- `rom_wdata`  out  8  constant 0x00.
- `rom_rdata`  in  8  glyph row, valid the cycle after `rom_cs`.
- `pix_valid`  out  1  pixel present.
- `pix_ready`  in  1  consumer takes the pixel.
- `pix_on`  out  1  glyph bit of the current pixel.
- `pix_color`  out  4  `pix_on` ? fg : bg.

## Operation
- Fetch FSM states: IDLE, ADDR, DATA, HOLD.
  - IDLE: `char_ready`=1. On `char_valid`, register code/attr/address and go to ADDR.
  - ADDR: `rom_cs`=1 and `rom_addr`={code,row_q} for exactly this cycle; go to DATA.
  - DATA: `rom_rdata` is valid.
    - If the shifter can load, load it from `rom_rdata` plus attr and go to IDLE.
    - Otherwise copy `rom_rdata` into the hold register and go to HOLD.
  - HOLD: when the shifter can load, load from the hold register and go to IDLE.
- `char_ready`=0 outside IDLE, while `rst`=1, and while `line_start`=1.
- Shifter: 8-bit shift register, attr register, count 0–8.
  - `pix_valid` = (count≠0). `pix_on` = shift[7].
  - On `pix_valid`&`pix_ready`: shift left and decrement count.
  - Can load = (count==0) or (count==1 and `pix_ready`). Loading sets count to 8.
- Pixel order: bit 7 is the leftmost pixel.
- `line_start`: latch `row`, force FSM to IDLE, count to 0, discard hold data. Any read in flight is ignored.
- `rst` has priority over `line_start`. `row_q` resets to 0.

## Timing
- Reset values:
  - `char_ready`=0, `rom_cs`=0, `rom_addr`=0.
  - `pix_valid`=0, `pix_on`=0, `pix_color`=0.
  - FSM in IDLE; count=0.
- Handshake at edge N: `rom_cs` high in cycle N+1, rdata captured at edge N+2, first `pix_valid` in cycle N+3 when the shifter is empty.
- Steady state with `pix_ready`=1: glyphs are prefetched, so there is no bubble between consecutive characters (8 pixels per character, continuous).
- Stall (`pix_ready`=0):
  - All pixel outputs hold.
  - The FSM parks in HOLD and does not accept further pairs.
- `line_start` in cycle M: `pix_valid`=0 and `rom_cs`=0 in cycle M+1; `char_ready`=1 in M+1.

## Configuration
- `TEXT_BLINK_EN` defined:
  - attr[7] is the blink bit; bg = {0, attr[6:4]}.
  - When attr[7]=1 and `blink_phase`=1, fg is replaced by bg.
- `TEXT_BLINK_EN` undefined:
  - bg = attr[7:4], 16 background colours.
  - `blink_phase` is ignored.

## Test plan
- Reset: hold `rst` 3 cycles, then release → all outputs 0 during reset; `char_ready`=1 in the first cycle after release; `rom_we`=0 and `rom_wdata`=0x00 always.
- Single glyph: `line_start` with row=5; handshake 'A' (0x41), attr 0x1E; `pix_ready`=1; ROM model returns 0xC6 at 0x415 → `rom_addr`=0x415 with `rom_cs` in N+1; pixels from N+3 are `pix_color` E,E,1,1,1,E,E,1, then `pix_valid`=0.
- Back-to-back: stream 0x41, 0x42 at row 5 with `char_valid`=1 → 16 consecutive `pix_valid` cycles; second glyph 0x66 gives colours 1,E,E,1,1,E,E,1.
- Stall: drop `pix_ready` after pixel 3 for 10 cycles with the next char offered → outputs frozen; FSM in HOLD; `char_ready`=0; remaining 5 pixels and then the next glyph continue unbroken.
- Flush: `line_start` (row=2) during pixel 4 with a read in flight → `pix_valid`=0 next cycle; the in-flight data never appears; the next char is fetched at address {code,2}.
- Blink: attr 0x9E, `blink_phase`=1, glyph 0xC6.
  - With `TEXT_BLINK_EN`: all 8 pixels colour 1.
  - Without `TEXT_BLINK_EN`: E,E,9,9,9,E,E,9.
